// File: rtl/input_mux_pkg.sv
// Purpose: shared mode encodings and select-code helpers for the input selector.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package input_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // The select code just past the last channel index emits zero words.
  function automatic int unsigned zero_code(input int unsigned n_ch);
    return n_ch;
  endfunction

endpackage

// File: rtl/input_mux_pipe_rr_arbiter.sv
// Purpose: round-robin grant over a request vector, starting the search at ptr.
// Latency: purely combinational; ptr update is returned as next_ptr for the caller's register.
// Backpressure: advance (asserted only on an actual transfer) is the sole ptr-moving event.
module rr_arbiter
  import input_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             advance,
  output logic [N_CH-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic [PTR_W-1:0] next_ptr
);

  // Scan from ptr upward, wrapping mod N_CH; first requester wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] scan_idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    scan_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      scan_idx = PTR_W'(idx);
      if (!grant_vld && req[scan_idx]) begin
        grant_vld       = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner only when its beat actually transfers.
  always_comb begin
    next_ptr = ptr;
    if (advance && grant_vld) begin
      if (int'(grant_idx) == N_CH - 1) begin
        next_ptr = '0;
      end else begin
        next_ptr = grant_idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_mux_pipe.sv
// Purpose: N-channel valid/ready input selector (fixed, zero-fill, idle, round-robin); INPUT_MUX_SKID_EN selects a 2-entry skid output.
// Latency: 1 clk from channel transfer to out_valid (skid variant: 1 clk when its FIFO is empty).
// Backpressure: base stage ch_ready = !out_valid || out_ready (comb path); skid variant drives ch_ready from a registered FIFO-space flag.
module input_mux_pipe
  import input_mux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_valid,
  output logic [N_CH-1:0]        ch_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int               PTR_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(zero_code(N_CH));
  localparam logic [SEL_W-1:0] NUM_CH   = SEL_W'(N_CH);

  logic [DATA_W-1:0] ch_word [N_CH];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  arb_next_ptr;
  logic [N_CH-1:0]   arb_grant;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_vld;
  logic              arb_advance;

  logic              accept;
  logic              load;
  logic              load_zero;
  logic [N_CH-1:0]   grant_vec;
  logic [PTR_W-1:0]  src_idx;
  logic [DATA_W-1:0] load_data;
  logic [SEL_W-1:0]  load_ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_word[i] = ch_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (ch_valid),
    .ptr       (rr_ptr),
    .advance   (arb_advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld),
    .next_ptr  (arb_next_ptr)
  );

  // Decode mode/sel into a grant, a load strobe and the word to load.
  always_comb begin
    grant_vec = '0;
    src_idx   = '0;
    load      = 1'b0;
    load_zero = 1'b0;
    if (mode == MODE_RR) begin
      if (arb_vld) begin
        grant_vec = arb_grant;
        src_idx   = arb_idx;
        load      = accept;
      end
    end else if (sel < NUM_CH) begin
      src_idx            = sel[PTR_W-1:0];
      grant_vec[src_idx] = 1'b1;
      load               = accept && ch_valid[src_idx];
    end else if (sel == ZERO_SEL) begin
      load_zero = 1'b1;
      load      = accept;
    end
    load_data = load_zero ? '0 : ch_word[src_idx];
    load_ch   = load_zero ? ZERO_SEL : SEL_W'(src_idx);
    // Holding reset must never hand a beat to us that we would then discard.
    ch_ready  = rst_n ? (grant_vec & {N_CH{accept}}) : '0;
  end

  assign arb_advance = (mode == MODE_RR) && load;

  // Round-robin pointer; only moves on a round-robin transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= arb_next_ptr;
    end
  end

`ifdef INPUT_MUX_SKID_EN

  logic [DATA_W-1:0] fifo_data [2];
  logic [SEL_W-1:0]  fifo_ch   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              accept_q;
  logic              pop;

  // Space flag is registered so out_ready never reaches ch_ready combinationally.
  assign accept     = accept_q;
  assign pop        = out_valid && out_ready;
  assign count_next = count + {1'b0, load} - {1'b0, pop};

  // Two-entry in-order FIFO; out_ch is stored alongside each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_ch[0]   <= '0;
      fifo_ch[1]   <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
      accept_q     <= 1'b0;
    end else begin
      if (load) begin
        fifo_data[wr_ptr] <= load_data;
        fifo_ch[wr_ptr]   <= load_ch;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count    <= count_next;
      accept_q <= (count_next < 2'd2);
    end
  end

  // Head entry drives the output.
  always_comb begin
    out_valid = (count != 2'd0);
    out_data  = fifo_data[rd_ptr];
    out_ch    = fifo_ch[rd_ptr];
  end

`else

  assign accept = !out_valid || out_ready;

  // Single output register; holds while stalled, clears valid when drained with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= load;
      if (load) begin
        out_data <= load_data;
        out_ch   <= load_ch;
      end
    end
  end

`endif

endmodule

// File: tb/tb_input_mux_pipe.sv
module tb_input_mux_pipe;
  import input_mux_pkg::*;

  localparam int DATA_W = 32;
  localparam int N_CH   = 4;
  localparam int SEL_W  = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH-1:0]        ch_ready;
  logic [DATA_W-1:0]      out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_valid;
  logic                   out_ready;

  always #5 clk = ~clk;

  input_mux_pipe #(.DATA_W(DATA_W), .N_CH(N_CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  ch;
  } beat_t;

  beat_t             exp_q[$];
  logic              mdl_valid;
  int                mdl_ptr;
  int                total = 0;
  int                bad   = 0;
  logic [DATA_W-1:0] base [N_CH];
  logic [DATA_W-1:0] step [N_CH];
  int                cnt  [N_CH];
  int                lim  [N_CH];

  function automatic logic [DATA_W-1:0] word_of(input int i);
    return base[i] + step[i] * DATA_W'(cnt[i]);
  endfunction

  task automatic set_chan(input int i, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] s, input int l);
    base[i] = b; step[i] = s; cnt[i] = 0; lim[i] = l;
  endtask

  // Bench model of the selector decision for the current inputs.
  function automatic void model_grant(output int g, output logic has, output logic zero);
    g = 0; has = 1'b0; zero = 1'b0;
    if (mode == MODE_RR) begin
      for (int k = 0; k < N_CH; k++) begin
        int idx;
        idx = (mdl_ptr + k) % N_CH;
        if (!has && ch_valid[idx]) begin has = 1'b1; g = idx; end
      end
    end else if (int'(sel) < N_CH) begin
      g = int'(sel); has = 1'b1;
    end else if (int'(sel) == N_CH) begin
      zero = 1'b1;
    end
  endfunction

  function automatic logic [N_CH-1:0] exp_ready();
    int g; logic has; logic zero; logic acc;
    logic [N_CH-1:0] r;
    acc = !mdl_valid || out_ready;
    model_grant(g, has, zero);
    r = '0;
    if (has) r[g] = acc;
    return r;
  endfunction

  // Advance the model across the coming clock edge; reports any beat it retires.
  task automatic model_step(output logic popped, output beat_t pb);
    int g; logic has; logic zero; logic acc; logic ld;
    beat_t nb;
    acc = !mdl_valid || out_ready;
    model_grant(g, has, zero);
    popped = mdl_valid && out_ready;
    pb = '0;
    if (popped) pb = exp_q.pop_front();
    ld = acc && (zero || (has && ch_valid[g]));
    if (ld) begin
      if (zero) begin
        nb.data = '0; nb.ch = SEL_W'(N_CH);
      end else begin
        nb.data = word_of(g); nb.ch = SEL_W'(g);
        cnt[g] = cnt[g] + 1;
        if (mode == MODE_RR) mdl_ptr = (g + 1) % N_CH;
      end
      exp_q.push_back(nb);
    end
    if (acc) mdl_valid = ld;
  endtask

  task automatic drive_cycle(input logic m, input logic [SEL_W-1:0] s, input logic [N_CH-1:0] vmask, input logic r);
    @(posedge clk);
    #1;
    mode = m; sel = s; out_ready = r;
    for (int i = 0; i < N_CH; i++) begin
      ch_valid[i] = vmask[i] && (cnt[i] < lim[i]);
      ch_data[i*DATA_W +: DATA_W] = word_of(i);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = MODE_FIXED; sel = '0; out_ready = 1'b1;
    ch_valid = '1; ch_data = {32'h33, 32'h22, 32'h11, 32'h00};
    for (int i = 0; i < N_CH; i++) set_chan(i, '0, '0, 0);
    exp_q.delete(); mdl_valid = 1'b0; mdl_ptr = 0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_ch !== '0) begin bad++; $display("FAIL reset_out_ch got=%0d want=0", out_ch); end
    total++; if (ch_ready !== '0) begin bad++; $display("FAIL reset_ch_ready got=%b want=0000", ch_ready); end
    ch_valid = '0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_sel();
    logic popped; beat_t pb; int beats = 0;
    set_chan(1, 32'hA0, 32'h1, 4);
    for (int c = 0; c < 7; c++) begin
      drive_cycle(MODE_FIXED, 3'd1, 4'b0010, 1'b1);
      total++; if (out_valid !== mdl_valid) begin bad++; $display("FAIL fixed_valid c=%0d got=%b want=%b", c, out_valid, mdl_valid); end
      total++; if (ch_ready !== exp_ready()) begin bad++; $display("FAIL fixed_ready c=%0d got=%b want=%b", c, ch_ready, exp_ready()); end
      if (mdl_valid) begin
        total++; if (out_data !== exp_q[0].data || out_ch !== exp_q[0].ch) begin bad++; $display("FAIL fixed_beat c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_ch, exp_q[0].data, exp_q[0].ch); end
      end
      model_step(popped, pb);
      if (popped) begin
        total++; if (pb.data !== 32'hA0 + DATA_W'(beats) || pb.ch !== 3'd1) begin bad++; $display("FAIL fixed_seq n=%0d got=%h/%0d want=%h/1", beats, pb.data, pb.ch, 32'hA0 + DATA_W'(beats)); end
        beats++;
      end
    end
    total++; if (beats !== 4) begin bad++; $display("FAIL fixed_count got=%0d want=4", beats); end
  endtask

  task automatic test_zero_fill();
    logic popped; beat_t pb; int beats = 0;
    logic rdy_pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < N_CH; i++) set_chan(i, 32'h100 * DATA_W'(i), 32'h1, 100);
    for (int c = 0; c < 9; c++) begin
      // Last two cycles use an idle code so the held zero beat drains.
      drive_cycle(MODE_FIXED, (c < 7) ? 3'd4 : 3'd6, 4'b1111, rdy_pat[c]);
      total++; if (out_valid !== mdl_valid) begin bad++; $display("FAIL zero_valid c=%0d got=%b want=%b", c, out_valid, mdl_valid); end
      total++; if (ch_ready !== 4'b0000) begin bad++; $display("FAIL zero_ready c=%0d got=%b want=0000", c, ch_ready); end
      if (mdl_valid) begin
        total++; if (out_data !== exp_q[0].data || out_ch !== exp_q[0].ch) begin bad++; $display("FAIL zero_beat c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_ch, exp_q[0].data, exp_q[0].ch); end
      end
      model_step(popped, pb);
      if (popped) begin
        total++; if (pb.data !== '0 || pb.ch !== 3'd4) begin bad++; $display("FAIL zero_seq got=%h/%0d want=0/4", pb.data, pb.ch); end
        beats++;
      end
    end
    total++; if (beats !== 5) begin bad++; $display("FAIL zero_count got=%0d want=5", beats); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_rr_all();
    logic popped; beat_t pb; int beats = 0;
    logic [DATA_W-1:0] exp_data [8] = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h00, 32'h10, 32'h20, 32'h30};
    for (int i = 0; i < N_CH; i++) set_chan(i, 32'h10 * DATA_W'(i), 32'h0, 2);
    for (int c = 0; c < 11; c++) begin
      drive_cycle(MODE_RR, 3'd6, 4'b1111, 1'b1);
      total++; if (out_valid !== mdl_valid) begin bad++; $display("FAIL rr_valid c=%0d got=%b want=%b", c, out_valid, mdl_valid); end
      total++; if (ch_ready !== exp_ready()) begin bad++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, ch_ready, exp_ready()); end
      if (mdl_valid) begin
        total++; if (out_data !== exp_q[0].data || out_ch !== exp_q[0].ch) begin bad++; $display("FAIL rr_beat c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_ch, exp_q[0].data, exp_q[0].ch); end
      end
      model_step(popped, pb);
      if (popped) begin
        if (beats < 8) begin
          total++; if (pb.data !== exp_data[beats]) begin bad++; $display("FAIL rr_seq n=%0d got=%h want=%h", beats, pb.data, exp_data[beats]); end
        end
        beats++;
      end
    end
    total++; if (beats !== 8) begin bad++; $display("FAIL rr_count got=%0d want=8", beats); end
  endtask

  task automatic test_rr_sparse();
    logic popped; beat_t pb; int beats = 0;
    logic [SEL_W-1:0] exp_ch [4] = '{3'd1, 3'd3, 3'd1, 3'd3};
    for (int i = 0; i < N_CH; i++) set_chan(i, 32'h50 + DATA_W'(i), 32'h0, 2);
    for (int c = 0; c < 7; c++) begin
      drive_cycle(MODE_RR, 3'd0, 4'b1010, 1'b1);
      total++; if (ch_ready !== exp_ready()) begin bad++; $display("FAIL sparse_ready c=%0d got=%b want=%b", c, ch_ready, exp_ready()); end
      total++; if ((ch_ready[0] | ch_ready[2]) !== 1'b0) begin bad++; $display("FAIL sparse_unreq c=%0d got=%b want=x0x0", c, ch_ready); end
      if (mdl_valid) begin
        total++; if (out_data !== exp_q[0].data || out_ch !== exp_q[0].ch) begin bad++; $display("FAIL sparse_beat c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_ch, exp_q[0].data, exp_q[0].ch); end
      end
      model_step(popped, pb);
      if (popped) begin
        if (beats < 4) begin
          total++; if (pb.ch !== exp_ch[beats]) begin bad++; $display("FAIL sparse_seq n=%0d got=%0d want=%0d", beats, pb.ch, exp_ch[beats]); end
        end
        beats++;
      end
    end
    total++; if (beats !== 4) begin bad++; $display("FAIL sparse_count got=%0d want=4", beats); end
  endtask

  task automatic test_stall();
    logic popped; beat_t pb; int beats = 0;
    for (int i = 0; i < N_CH; i++) set_chan(i, '0, '0, 0);
    set_chan(2, 32'h200, 32'h1, 4);
    for (int c = 0; c < 10; c++) begin
      drive_cycle(MODE_FIXED, 3'd2, 4'b0100, !(c >= 1 && c <= 3));
      total++; if (out_valid !== mdl_valid) begin bad++; $display("FAIL stall_valid c=%0d got=%b want=%b", c, out_valid, mdl_valid); end
      total++; if (ch_ready !== exp_ready()) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=%b", c, ch_ready, exp_ready()); end
      if (c >= 1 && c <= 3) begin
        total++; if (out_data !== 32'h200 || ch_ready[2] !== 1'b0) begin bad++; $display("FAIL stall_hold c=%0d got=%h/%b want=200/0", c, out_data, ch_ready[2]); end
      end
      if (mdl_valid) begin
        total++; if (out_data !== exp_q[0].data || out_ch !== exp_q[0].ch) begin bad++; $display("FAIL stall_beat c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_ch, exp_q[0].data, exp_q[0].ch); end
      end
      model_step(popped, pb);
      if (popped) begin
        total++; if (pb.data !== 32'h200 + DATA_W'(beats)) begin bad++; $display("FAIL stall_seq n=%0d got=%h want=%h", beats, pb.data, 32'h200 + DATA_W'(beats)); end
        beats++;
      end
    end
    total++; if (beats !== 4) begin bad++; $display("FAIL stall_count got=%0d want=4", beats); end
  endtask

  task automatic test_reset_mid();
    logic popped; beat_t pb; int beats = 0;
    for (int i = 0; i < N_CH; i++) set_chan(i, 32'h400 + 32'h10 * DATA_W'(i), 32'h1, 100);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(MODE_RR, 3'd0, 4'b1111, 1'b1);
      if (mdl_valid) begin
        total++; if (out_data !== exp_q[0].data || out_ch !== exp_q[0].ch) begin bad++; $display("FAIL mid_pre c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_ch, exp_q[0].data, exp_q[0].ch); end
      end
      model_step(popped, pb);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL mid_reset_out got=%b/%h want=0/0", out_valid, out_data); end
    total++; if (ch_ready !== '0) begin bad++; $display("FAIL mid_reset_ready got=%b want=0000", ch_ready); end
    ch_valid = '0;
    exp_q.delete(); mdl_valid = 1'b0; mdl_ptr = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(MODE_RR, 3'd0, 4'b1111, 1'b1);
      total++; if (out_valid !== mdl_valid) begin bad++; $display("FAIL mid_valid c=%0d got=%b want=%b", c, out_valid, mdl_valid); end
      if (mdl_valid) begin
        total++; if (out_data !== exp_q[0].data || out_ch !== exp_q[0].ch) begin bad++; $display("FAIL mid_beat c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_ch, exp_q[0].data, exp_q[0].ch); end
      end
      model_step(popped, pb);
      if (popped) begin
        if (beats == 0) begin
          total++; if (pb.ch !== 3'd0) begin bad++; $display("FAIL mid_restart got=%0d want=0", pb.ch); end
        end
        beats++;
      end
    end
    total++; if (beats !== 3) begin bad++; $display("FAIL mid_count got=%0d want=3", beats); end
  endtask

  initial begin
    test_reset();
    test_fixed_sel();
    test_zero_fill();
    test_rr_all();
    test_rr_sparse();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
